// File: rtl/resonator_dds_mul_arbiter.sv
// resonator_dds_mul_arbiter: round-robin arbiter sharing one 2-stage signed
// 16x16 multiplier among NUM_REQ requesters, with the requester ID carried
// alongside the product and full backpressure from the output.
// Optional feature macro: RESONATOR_DDS_MUL_ARB_PRIO0_EN (requester 0 gets
// strict priority; others round-robin among themselves).

module resonator_dds_mulg8j (
   input  logic               clk,
   input  logic               ce_i,
   input  logic signed [15:0] a_i,
   input  logic signed [15:0] b_i,
   output logic signed [31:0] p_o
);
   logic signed [15:0] a_q;
   logic signed [15:0] b_q;
   logic signed [31:0] p_q;

   // operand stage then product stage; no reset, contents are qualified by the tag pipe
   always_ff @(posedge clk) begin
      if (ce_i) begin
         a_q <= a_i;
         b_q <= b_i;
         p_q <= a_q * b_q;
      end
   end

   assign p_o = p_q;
endmodule

module resonator_dds_mul_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [16*NUM_REQ-1:0]   req_a,
   input  logic [16*NUM_REQ-1:0]   req_b,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [31:0]             out_p,
   output logic [ID_W-1:0]         out_id
);
   logic               adv;
   logic               hs;
   logic               gnt_found;
   logic [ID_W-1:0]    gnt_idx;
   logic signed [15:0] sel_a;
   logic signed [15:0] sel_b;
   logic signed [31:0] prod;

   logic               v1_q,  v1_d;
   logic               v2_q,  v2_d;
   logic [ID_W-1:0]    id1_q, id1_d;
   logic [ID_W-1:0]    id2_q, id2_d;
   logic [ID_W-1:0]    rr_q,  rr_d;

   // the whole pipe moves only when the output slot is empty or being drained
   assign adv = !v2_q || out_ready;
   assign hs  = adv && gnt_found && !reset;

   // grant: first valid requester at or after rr_ptr, searching upward with wrap
   always_comb begin
      int              j;
      logic [ID_W-1:0] idx;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      j         = 0;
      idx       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(rr_q) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         idx = ID_W'(j);
         if (!gnt_found && req_valid[idx]) begin
            gnt_found = 1'b1;
            gnt_idx   = idx;
         end
      end
`ifdef RESONATOR_DDS_MUL_ARB_PRIO0_EN
      if (req_valid[0]) begin
         gnt_found = 1'b1;
         gnt_idx   = '0;
      end
`endif
   end

   // operand mux for the granted requester
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_idx == ID_W'(i)) begin
            sel_a = req_a[16*i +: 16];
            sel_b = req_b[16*i +: 16];
         end
      end
   end

   assign req_ready = hs ? (NUM_REQ'(1) << gnt_idx) : '0;

   // next state for the tag pipe and the round-robin pointer
   always_comb begin
      v1_d  = v1_q;
      v2_d  = v2_q;
      id1_d = id1_q;
      id2_d = id2_q;
      rr_d  = rr_q;
      if (adv) begin
         v2_d  = v1_q;
         id2_d = id1_q;
         v1_d  = hs;
         if (hs) id1_d = gnt_idx;
      end
      if (hs) begin
`ifdef RESONATOR_DDS_MUL_ARB_PRIO0_EN
         if (gnt_idx != '0)
            rr_d = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
`else
         rr_d = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
`endif
      end
   end

   // control registers; reset wins over any simultaneous handshake
   always_ff @(posedge clk) begin
      if (reset) begin
         v1_q  <= 1'b0;
         v2_q  <= 1'b0;
         id1_q <= '0;
         id2_q <= '0;
         rr_q  <= '0;
      end else begin
         v1_q  <= v1_d;
         v2_q  <= v2_d;
         id1_q <= id1_d;
         id2_q <= id2_d;
         rr_q  <= rr_d;
      end
   end

   resonator_dds_mulg8j u_mul (
      .clk  (clk),
      .ce_i (adv),
      .a_i  (sel_a),
      .b_i  (sel_b),
      .p_o  (prod)
   );

   assign out_valid = v2_q;
   assign out_id    = id2_q;
   assign out_p     = v2_q ? prod : 32'd0;
endmodule
